// File: rtl/mpu_det_seq.sv
// ============================================================================
// Module      : mpu_det_seq
// Description : Sequential Bareiss determinant engine, one element update
//               per cycle, with row-swap pivoting and saturated output.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mpu_det_seq #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int ACC_W  = 48
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_W*MAX_N*MAX_N-1:0]    matrix,
  input  logic [7:0]                       size,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_W-1:0]                result,
  output logic [ACC_W-1:0]                 result_wide,
  output logic                             overflow,
  output logic                             error
);

  localparam int c_IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LOAD   = 3'd1;
  localparam logic [2:0] c_PIVOT  = 3'd2;
  localparam logic [2:0] c_SEARCH = 3'd3;
  localparam logic [2:0] c_SWAP   = 3'd4;
  localparam logic [2:0] c_ELIM   = 3'd5;
  localparam logic [2:0] c_FINISH = 3'd6;

  localparam logic signed [ACC_W-1:0] c_SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [2:0]              r_state, w_next;
  logic [c_IW-1:0]         r_nm1, r_k, r_i, r_j, w_kp1;
  logic                    r_err, r_sing, r_neg;
  logic signed [ACC_W-1:0] r_prev;
  logic signed [ACC_W-1:0] r_w [MAX_N][MAX_N];

  logic                      w_accept, w_size_bad, w_last_ij;
  logic signed [ACC_W-1:0]   w_wkk, w_wij, w_wik, w_wkj, w_wlast, w_upd, w_det;
  logic signed [2*ACC_W-1:0] w_p1, w_p2;
  logic                      w_ovf;
  logic [DATA_W-1:0]         w_sat;

  assign w_accept   = (r_state == c_IDLE) && start;
  assign w_size_bad = (size == 8'd0) || (size > 8'(MAX_N));
  assign w_kp1      = r_k + c_IW'(1);
  assign w_last_ij  = (r_i == r_nm1) && (r_j == r_nm1);

  assign w_wkk   = r_w[r_k][r_k];
  assign w_wij   = r_w[r_i][r_j];
  assign w_wik   = r_w[r_i][r_k];
  assign w_wkj   = r_w[r_k][r_j];
  assign w_wlast = r_w[r_nm1][r_nm1];

  // Bareiss step at double width; the division by the previous pivot is exact.
  assign w_p1  = (2*ACC_W)'(w_wij) * (2*ACC_W)'(w_wkk);
  assign w_p2  = (2*ACC_W)'(w_wik) * (2*ACC_W)'(w_wkj);
  assign w_upd = ACC_W'((w_p1 - w_p2) / (2*ACC_W)'(r_prev));

  assign w_det = (r_err || r_sing) ? '0 : (r_neg ? -w_wlast : w_wlast);
  assign w_ovf = (w_det > c_SMAX) || (w_det < c_SMIN);
  assign w_sat = (w_det > c_SMAX) ? c_SMAX[DATA_W-1:0] :
                 (w_det < c_SMIN) ? c_SMIN[DATA_W-1:0] : w_det[DATA_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (start) w_next = c_LOAD;
      c_LOAD:   w_next = (r_err || r_nm1 == '0) ? c_FINISH : c_PIVOT;
      c_PIVOT:  w_next = (w_wkk != '0) ? c_ELIM : c_SEARCH;
      c_SEARCH: begin
        if (w_wik != '0)         w_next = c_SWAP;
        else if (r_i == r_nm1)   w_next = c_FINISH;
      end
      c_SWAP:   w_next = c_ELIM;
      c_ELIM:   if (w_last_ij) w_next = (w_kp1 == r_nm1) ? c_FINISH : c_PIVOT;
      c_FINISH: w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != c_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_nm1       <= '0;
      r_k         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_err       <= 1'b0;
      r_sing      <= 1'b0;
      r_neg       <= 1'b0;
      r_prev      <= ACC_W'(1);
      done        <= 1'b0;
      result      <= '0;
      result_wide <= '0;
      overflow    <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_IDLE: if (start) begin
          r_nm1  <= w_size_bad ? '0 : c_IW'(size - 8'd1);
          r_err  <= w_size_bad;
          r_sing <= 1'b0;
          r_neg  <= 1'b0;
          r_k    <= '0;
          r_prev <= ACC_W'(1);
        end
        c_PIVOT: begin
          r_i <= w_kp1;
          r_j <= w_kp1;
        end
        c_SEARCH: if (w_wik == '0) begin
          if (r_i == r_nm1) r_sing <= 1'b1;
          else              r_i    <= r_i + c_IW'(1);
        end
        c_SWAP: begin
          r_neg <= ~r_neg;
          r_i   <= w_kp1;
          r_j   <= w_kp1;
        end
        c_ELIM: begin
          if (r_j == r_nm1) begin
            if (r_i == r_nm1) begin
              r_prev <= w_wkk;
              r_k    <= w_kp1;
            end else begin
              r_i <= r_i + c_IW'(1);
              r_j <= w_kp1;
            end
          end else begin
            r_j <= r_j + c_IW'(1);
          end
        end
        c_FINISH: begin
          result_wide <= w_det;
          result      <= w_sat;
          overflow    <= w_ovf;
          error       <= r_err;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Working matrix: loaded on accept, rows exchanged in SWAP, one entry per ELIM cycle.
  always_ff @(posedge clock) begin
    for (int r = 0; r < MAX_N; r++) begin
      for (int c = 0; c < MAX_N; c++) begin
        if (w_accept) begin
          r_w[r][c] <= ACC_W'($signed(matrix[DATA_W*(c+MAX_N*r) +: DATA_W]));
        end else if (r_state == c_SWAP && c_IW'(c) >= r_k) begin
          if (c_IW'(r) == r_k)      r_w[r][c] <= r_w[r_i][c];
          else if (c_IW'(r) == r_i) r_w[r][c] <= r_w[r_k][c];
        end else if (r_state == c_ELIM && c_IW'(r) == r_i && c_IW'(c) == r_j) begin
          r_w[r][c] <= w_upd;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mpu_det_seq.sv
// ============================================================================
// Module      : tb_mpu_det_seq
// Description : Directed scoreboard bench for mpu_det_seq against a
//               permutation-sum determinant model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mpu_det_seq;

  localparam int DW = 8;
  localparam int MN = 5;
  localparam int AW = 48;

  logic              clock = 1'b0;
  logic              reset, start;
  logic [DW*MN*MN-1:0] matrix;
  logic [7:0]        size;
  logic              busy, done, overflow, error;
  logic [DW-1:0]     result;
  logic [AW-1:0]     result_wide;

  mpu_det_seq #(.DATA_W(DW), .MAX_N(MN), .ACC_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .matrix(matrix), .size(size),
    .busy(busy), .done(done), .result(result), .result_wide(result_wide),
    .overflow(overflow), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] wide;
    logic [DW-1:0] res;
    logic          ovf;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Leibniz sum over all permutations of the top-left n x n block.
  function automatic longint det_model(input logic [DW*MN*MN-1:0] m, input int n);
    longint acc, prod;
    int total, x, inv;
    int p[MN];
    bit ok;
    acc = 0;
    if (n < 1 || n > MN) return 0;
    total = 1;
    for (int q = 0; q < n; q++) total *= n;
    for (int t = 0; t < total; t++) begin
      x = t; ok = 1'b1; inv = 0; prod = 1;
      for (int r = 0; r < n; r++) begin p[r] = x % n; x = x / n; end
      for (int a = 0; a < n; a++)
        for (int b = a + 1; b < n; b++) begin
          if (p[a] == p[b]) ok = 1'b0;
          if (p[a] > p[b])  inv++;
        end
      if (ok) begin
        for (int r = 0; r < n; r++) prod *= longint'($signed(m[DW*(p[r]+MN*r) +: DW]));
        acc += (inv % 2 == 1) ? -prod : prod;
      end
    end
    return acc;
  endfunction

  function automatic logic [DW*MN*MN-1:0] pk(input int a[MN*MN]);
    logic [DW*MN*MN-1:0] v;
    int e;
    v = '0;
    for (int i = 0; i < MN*MN; i++) begin
      e = a[i];
      v[DW*i +: DW] = e[DW-1:0];
    end
    return v;
  endfunction

  task automatic expect_job(input logic [DW*MN*MN-1:0] m, input int n, input int lat);
    exp_t   e;
    longint d;
    d     = det_model(m, n);
    e.wide = d[AW-1:0];
    e.err  = (n < 1 || n > MN);
    e.ovf  = (d > 127) || (d < -128);
    if (d > 127)       e.res = 8'h7f;
    else if (d < -128) e.res = 8'h80;
    else               e.res = d[DW-1:0];
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic launch(input logic [DW*MN*MN-1:0] m, input int n);
    @(negedge clock);
    matrix = m;
    size   = 8'(n);
    start  = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic check_done(input string tag, input int cyc);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected_done"}, {63'd0, done}, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_result"},   {56'd0, result},      {56'd0, e.res});
    chk({tag, "_wide"},     {16'd0, result_wide}, {16'd0, e.wide});
    chk({tag, "_overflow"}, {63'd0, overflow},    {63'd0, e.ovf});
    chk({tag, "_error"},    {63'd0, error},       {63'd0, e.err});
    chk({tag, "_busy"},     {63'd0, busy},        64'd0);
    if (e.lat > 0) chk({tag, "_latency"}, 64'(cyc), 64'(e.lat));
  endtask

  task automatic await_done(input string tag);
    int c;
    c = 0;
    while (!done && c < 300) begin
      @(posedge clock);
      #1 c++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, {63'd0, done}, 64'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      check_done(tag, c);
    end
  endtask

  task automatic run(input string tag, input logic [DW*MN*MN-1:0] m, input int n, input int lat);
    expect_job(m, n, lat);
    launch(m, n);
    await_done(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a[MN*MN];
    int id5[MN*MN];
    int dones;
    logic [DW*MN*MN-1:0] m, mid;
    logic [DW*MN*MN-1:0] rnd;

    reset = 1'b1; start = 1'b0; matrix = '0; size = 8'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",     {63'd0, busy},        64'd0);
    chk("rst_done",     {63'd0, done},        64'd0);
    chk("rst_result",   {56'd0, result},      64'd0);
    chk("rst_wide",     {16'd0, result_wide}, 64'd0);
    chk("rst_overflow", {63'd0, overflow},    64'd0);
    chk("rst_error",    {63'd0, error},       64'd0);
    @(negedge clock) reset = 1'b0;

    for (int i = 0; i < MN*MN; i++) id5[i] = (i % (MN+1) == 0) ? 1 : 0;
    mid = pk(id5);
    run("ident5", mid, 5, 36);
    @(posedge clock); #1;
    chk("ident5_done_pulse", {63'd0, done}, 64'd0);

    a = '{3,1,0,0,0, 4,2,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    run("m2x2", pk(a), 2, 4);
    // this operand is singular by cofactor expansion; no zero pivot occurs
    a = '{2,0,1,0,0, 1,3,2,0,0, 1,1,1,0,0, 0,0,0,0,0, 0,0,0,0,0};
    run("m3x3", pk(a), 3, 9);
    a = '{0,1,0,0,0, 1,0,0,0,0, 0,0,1,0,0, 0,0,0,0,0, 0,0,0,0,0};
    run("perm3", pk(a), 3, 11);
    a = '{1,2,0,3,0, 4,5,0,6,0, 7,8,0,9,0, 1,1,0,1,0, 0,0,0,0,0};
    run("sing4", pk(a), 4, 19);
    a = '{10,0,0,0,0, 0,10,0,0,0, 0,0,10,0,0, 0,0,0,10,0, 0,0,0,0,10};
    run("diag_pos", pk(a), 5, 36);
    a[24] = -10;
    run("diag_neg", pk(a), 5, 36);
    run("size0", mid, 0, 2);
    run("size6", mid, 6, 2);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < DW*MN*MN; i += 32) rnd[i +: 32] = $urandom;
      run($sformatf("rand%0d", t), rnd, 5 - t, 0);
    end

    // start pulsed while busy must be ignored
    a = '{0,1,0,0,0, 1,0,0,0,0, 0,0,1,0,0, 0,0,0,0,0, 0,0,0,0,0};
    m = pk(a);
    expect_job(m, 3, 11);
    launch(m, 3);
    dones = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clock); #1;
      if (done) begin
        dones++;
        check_done("busy_start", c);
      end
      if (c == 3) begin matrix = mid; size = 8'd5; start = 1'b1; end
      if (c == 4) start = 1'b0;
    end
    chk("busy_start_dones", 64'(dones), 64'd1);

    // reset during ELIM of a 5x5 job
    launch(mid, 5);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_busy",     {63'd0, busy},        64'd0);
    chk("abort_done",     {63'd0, done},        64'd0);
    chk("abort_result",   {56'd0, result},      64'd0);
    chk("abort_wide",     {16'd0, result_wide}, 64'd0);
    chk("abort_overflow", {63'd0, overflow},    64'd0);
    chk("abort_error",    {63'd0, error},       64'd0);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);

    a = '{3,1,0,0,0, 4,2,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
    run("after_abort", pk(a), 2, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
